// File: rtl/dspuva16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dspuva16_pkg
//  Description : Shared types and constants for the DSPuva16 frame sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package dspuva16_pkg;

    localparam int DATA_W = 24;
    localparam int CH_W   = 4;

    localparam logic [7:0] DEFAULT_DONE_PORT = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dsp_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_frame_sequencer_if
//  Description : Sample-stream, core-port and status bundle of the frame
//                sequencer. "slave" is the sequencer side, "master" is the
//                environment (sample sources, consumer and DSP core).
//  Revision    : 1.0  initial release
// ============================================================================
interface dsp_frame_sequencer_if;
    import dspuva16_pkg::*;

    logic              frame_stb;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_ready;
    logic              ping;
    logic [7:0]        port;
    logic              ior;
    logic              iow;
    logic [DATA_W-1:0] dout24;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              overrun;
    logic              underrun;
    logic              drop;
    logic              flag_clr;

    modport slave (
        input  frame_stb, in_valid, in_data, out_ready, port, ior, iow, dout24, flag_clr,
        output in_ready, out_valid, out_data, out_ch, ping, din, busy, overrun, underrun, drop
    );

    modport master (
        output frame_stb, in_valid, in_data, out_ready, port, ior, iow, dout24, flag_clr,
        input  in_ready, out_valid, out_data, out_ch, ping, din, busy, overrun, underrun, drop
    );

endinterface
`default_nettype wire

// File: rtl/dsp_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_out_fifo
//  Description : Synchronous FIFO with full/empty flags. A push while full is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module dsp_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_FULL);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    // Storage write; pointers are AW bits wide so they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_frame_sequencer
//  Description : Per-frame controller for the DSPuva16 core. Restarts the core
//                on every frame strobe, serves port reads from a double
//                buffered sample bank and collects port writes into a FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module dsp_frame_sequencer
    import dspuva16_pkg::*;
#(
    parameter int         NCH         = 4,
    parameter logic [7:0] DONE_PORT   = DEFAULT_DONE_PORT,
    parameter int         OFIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dsp_frame_sequencer_if.slave  bus
);

    localparam int              SC_W    = $clog2(NCH + 1);
    localparam logic [SC_W-1:0] SC_FULL = SC_W'(NCH);
    localparam int              ENTRY_W = CH_W + DATA_W;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shadow [NCH];
    logic [DATA_W-1:0] active [NCH];
    logic [SC_W-1:0]   sc;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] din_q;
    logic              ping_q;
    logic              overrun_q;
    logic              underrun_q;
    logic              drop_q;

    logic              bank_full;
    logic              in_xfer;
    logic              swap;
    logic              running;
    logic              iow_run;
    logic              push_req;
    logic              done_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              drop_evt;
    logic [ENTRY_W-1:0] fifo_head;

    // The read strobe carries no information: DIN is refreshed every cycle.
    logic              unused_ior;
    assign unused_ior = bus.ior;

    assign bank_full = (sc == SC_FULL);
    assign in_xfer   = bus.in_valid & ~bank_full;
    assign swap      = bus.frame_stb & bank_full;
    assign running   = (state == ST_RUN);
    assign iow_run   = bus.iow & running;
    assign push_req  = iow_run & (bus.port < 8'(NCH));
    assign done_wr   = iow_run & (bus.port == DONE_PORT);
    assign fifo_pop  = ~fifo_empty & bus.out_ready;
    assign drop_evt  = push_req & fifo_full & ~fifo_pop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a strobe always (re)starts a frame, even over a done write.
    always_comb begin
        state_nxt = state;
        if (bus.frame_stb) begin
            state_nxt = ST_RUN;
        end else if (done_wr) begin
            state_nxt = ST_IDLE;
        end
    end

    // Shadow bank fill; a swap empties it for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
            end
        end else if (swap) begin
            sc <= '0;
        end else if (in_xfer) begin
            sc <= sc + 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (sc == SC_W'(i)) begin
                    shadow[i] <= bus.in_data;
                end
            end
        end
    end

    // Active bank takes the whole shadow bank only when it was complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                active[i] <= '0;
            end
        end else if (swap) begin
            for (int i = 0; i < NCH; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Read mux over the active bank; out-of-range ports read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.port == 8'(i)) begin
                rd_word = active[i];
            end
        end
    end

    // Registered core read data and restart pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= '0;
            ping_q <= 1'b0;
        end else begin
            din_q  <= rd_word;
            ping_q <= bus.frame_stb;
        end
    end

    // Sticky status flags; a set event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            overrun_q  <= (bus.frame_stb & running)    | (overrun_q  & ~bus.flag_clr);
            underrun_q <= (bus.frame_stb & ~bank_full) | (underrun_q & ~bus.flag_clr);
            drop_q     <= drop_evt                     | (drop_q     & ~bus.flag_clr);
        end
    end

    dsp_out_fifo #(
        .DEPTH (OFIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_req),
        .pop     (fifo_pop),
        .wr_data ({bus.port[CH_W-1:0], bus.dout24}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.in_ready  = ~bank_full;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_ch    = fifo_head[ENTRY_W-1:DATA_W];
    assign bus.out_data  = fifo_head[DATA_W-1:0];
    assign bus.ping      = ping_q;
    assign bus.din       = din_q;
    assign bus.busy      = running;
    assign bus.overrun   = overrun_q;
    assign bus.underrun  = underrun_q;
    assign bus.drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_frame_sequencer
//  Description : Directed bench for dsp_frame_sequencer with a queue-based
//                reference model compared on every falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dsp_frame_sequencer;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    dsp_frame_sequencer_if ifc ();

    dsp_frame_sequencer #(
        .NCH         (NCH),
        .DONE_PORT   (8'hFF),
        .OFIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample banks and FIFO as queues, frame activity as a bit.
    logic [23:0] q_sh[$];
    logic [23:0] m_act[NCH];
    logic [27:0] q_fifo[$];
    bit          m_busy, m_ping, m_ovr, m_und, m_drop;
    logic [23:0] m_din;
    bit          e_pop, e_push, e_drop, e_ovr, e_und, e_swap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh.delete();
            q_fifo.delete();
            foreach (m_act[i]) m_act[i] = '0;
            m_busy = 0; m_ping = 0; m_ovr = 0; m_und = 0; m_drop = 0;
            m_din  = '0;
        end else begin
            m_din  = (ifc.port < NCH) ? m_act[ifc.port] : 24'h0;
            m_ping = ifc.frame_stb;
            e_pop  = (q_fifo.size() > 0) && ifc.out_ready;
            e_push = 0;
            e_drop = 0;
            if (ifc.iow && m_busy && ifc.port < NCH) begin
                if (q_fifo.size() < DEPTH || e_pop) e_push = 1;
                else                                e_drop = 1;
            end
            if (e_pop)  void'(q_fifo.pop_front());
            if (e_push) q_fifo.push_back({ifc.port[3:0], ifc.dout24});
            e_ovr  = ifc.frame_stb && m_busy;
            e_swap = ifc.frame_stb && (q_sh.size() == NCH);
            e_und  = ifc.frame_stb && !e_swap;
            if (ifc.frame_stb)                                m_busy = 1;
            else if (m_busy && ifc.iow && ifc.port == 8'hFF) m_busy = 0;
            if (e_swap) begin
                for (int i = 0; i < NCH; i++) m_act[i] = q_sh[i];
                q_sh.delete();
            end else if (ifc.in_valid && q_sh.size() != NCH) begin
                q_sh.push_back(ifc.in_data);
            end
            m_ovr  = e_ovr  || (m_ovr  && !ifc.flag_clr);
            m_und  = e_und  || (m_und  && !ifc.flag_clr);
            m_drop = e_drop || (m_drop && !ifc.flag_clr);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready",  32'(ifc.in_ready),  32'(q_sh.size() != NCH));
        chk("busy",      32'(ifc.busy),      32'(m_busy));
        chk("ping",      32'(ifc.ping),      32'(m_ping));
        chk("din",       32'(ifc.din),       32'(m_din));
        chk("overrun",   32'(ifc.overrun),   32'(m_ovr));
        chk("underrun",  32'(ifc.underrun),  32'(m_und));
        chk("drop",      32'(ifc.drop),      32'(m_drop));
        chk("out_valid", 32'(ifc.out_valid), 32'(q_fifo.size() != 0));
        if (q_fifo.size() != 0) begin
            chk("out_data", 32'(ifc.out_data), 32'(q_fifo[0][23:0]));
            chk("out_ch",   32'(ifc.out_ch),   32'(q_fifo[0][27:24]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [23:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = first + 24'(k);
            tick();
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic strobe();
        ifc.frame_stb = 1'b1;
        tick();
        ifc.frame_stb = 1'b0;
    endtask

    task automatic write(input logic [7:0] p, input logic [23:0] d);
        ifc.iow    = 1'b1;
        ifc.port   = p;
        ifc.dout24 = d;
        tick();
        ifc.iow    = 1'b0;
    endtask

    initial begin
        ifc.frame_stb = 0; ifc.in_valid = 0; ifc.in_data = '0; ifc.out_ready = 0;
        ifc.port = '0; ifc.ior = 0; ifc.iow = 0; ifc.dout24 = '0; ifc.flag_clr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_busy",      32'(ifc.busy),      0);
        chk("rst_in_ready",  32'(ifc.in_ready),  1);
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_ping",      32'(ifc.ping),      0);
        rst_n = 1'b1;
        tick();

        // A write while idle must not reach the FIFO.
        write(8'h00, 24'h000055);
        tick();
        chk("idle_iow", 32'(ifc.out_valid), 0);

        // Frame start with a complete bank.
        load(24'h000001, 4);
        chk("bank_full_ready", 32'(ifc.in_ready), 0);
        strobe();
        chk("t1_ping", 32'(ifc.ping), 1);
        chk("t1_busy", 32'(ifc.busy), 1);
        ifc.port = 8'd2;
        tick();
        chk("t1_ping_once", 32'(ifc.ping), 0);
        chk("t1_din",       32'(ifc.din),  32'h000003);

        // Channel write then frame-done write.
        write(8'd1, 24'hABCDEF);
        write(8'hFF, 24'h0);
        chk("t2_valid", 32'(ifc.out_valid), 1);
        chk("t2_ch",    32'(ifc.out_ch),    1);
        chk("t2_data",  32'(ifc.out_data),  32'hABCDEF);
        chk("t2_busy",  32'(ifc.busy),      0);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;

        // Strobe during a running frame; set beats clear.
        load(24'h000010, 4);
        strobe();
        tick();
        strobe();
        chk("t3_overrun", 32'(ifc.overrun), 1);
        chk("t3_ping",    32'(ifc.ping),    1);
        chk("t3_busy",    32'(ifc.busy),    1);
        ifc.flag_clr = 1'b1;
        strobe();
        chk("t3_set_wins", 32'(ifc.overrun), 1);
        tick();
        ifc.flag_clr = 1'b0;
        chk("t3_clr", 32'(ifc.overrun), 0);

        // Partial bank at the strobe: previous frame data stays active.
        load(24'h000020, 2);
        strobe();
        chk("t4_underrun", 32'(ifc.underrun), 1);
        chk("t4_in_ready", 32'(ifc.in_ready), 1);
        ifc.port = 8'd0;
        tick();
        chk("t4_din_prev", 32'(ifc.din), 32'h000010);
        load(24'h000022, 2);
        ifc.flag_clr = 1'b1;
        tick();
        ifc.flag_clr = 1'b0;

        // FIFO overflow, then push+pop while full.
        for (int i = 0; i < 5; i++) write(8'(i % 4), 24'h000100 + 24'(i));
        chk("t5_drop", 32'(ifc.drop),     1);
        chk("t5_head", 32'(ifc.out_data), 32'h000100);
        ifc.flag_clr = 1'b1;
        tick();
        ifc.flag_clr = 1'b0;
        ifc.out_ready = 1'b1;
        write(8'd2, 24'h0001FF);
        ifc.out_ready = 1'b0;
        chk("t5_no_drop", 32'(ifc.drop),     0);
        chk("t5_head2",   32'(ifc.out_data), 32'h000101);
        ifc.out_ready = 1'b1;
        repeat (3) tick();
        chk("t5_last", 32'(ifc.out_data), 32'h0001FF);
        tick();
        ifc.out_ready = 1'b0;
        chk("t5_empty", 32'(ifc.out_valid), 0);

        // Reset in the middle of a running frame.
        strobe();
        write(8'd0, 24'h000077);
        strobe();
        chk("t6_pre_ovr", 32'(ifc.overrun), 1);
        rst_n = 1'b0;
        tick();
        chk("t6_busy",      32'(ifc.busy),      0);
        chk("t6_out_valid", 32'(ifc.out_valid), 0);
        chk("t6_flags",     32'({ifc.overrun, ifc.underrun, ifc.drop}), 0);
        chk("t6_in_ready",  32'(ifc.in_ready),  1);
        chk("t6_ping",      32'(ifc.ping),      0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t6_no_ping", 32'(ifc.ping), 0);
        strobe();
        chk("t6_ping_after", 32'(ifc.ping), 1);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
